// File: rtl/tone_seq_player_pkg.sv
// Shared Simon types: tone codes and the sequencer state encoding.
package simon_pkg;

  typedef logic [2:0] tone_t;

  localparam tone_t TONE_RED = 3'd0;
  localparam tone_t TONE_GRN = 3'd1;
  localparam tone_t TONE_BLU = 3'd2;
  localparam tone_t TONE_YEL = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tone_seq_player_if.sv
// Control/speaker bundle for tone_seq_player: pattern write, play control, speaker drive.
interface tone_seq_player_if #(
  parameter int unsigned AW = 5
);
  import simon_pkg::*;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  tone_t         wr_tone;
  logic          start;
  logic [AW:0]   len;
  logic          abort;
  tone_t         tone_sel;
  logic          SE;
  logic          busy;
  logic          done;
  logic [AW-1:0] idx;

  modport master (
    output wr_en, wr_addr, wr_tone, start, len, abort,
    input  tone_sel, SE, busy, done, idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_tone, start, len, abort,
    output tone_sel, SE, busy, done, idx
  );

endinterface

// File: rtl/tone_seq_player_mem.sv
// Pattern store: DEPTH x 3-bit, one synchronous write port, one combinational read port.
module tone_seq_mem
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  tone_t         i_wr_tone,
  input  logic [AW-1:0] i_rd_addr,
  output tone_t         o_rd_tone
);

  tone_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en && (32'(i_wr_addr) < DEPTH))
      r_mem[i_wr_addr] <= i_wr_tone;
  end

  assign o_rd_tone = r_mem[i_rd_addr];

endmodule

// File: rtl/tone_seq_player.sv
// Simon tone sequencer: plays the first len pattern entries as tone/gap pairs on the speaker.
// Optional TONE_SPEEDUP_EN shortens the tone on-time as the sequence length grows.
module tone_seq_player
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned CW       = 24,
  parameter int unsigned TONE_CYC = 12_500_000,
  parameter int unsigned GAP_CYC  = 2_500_000
) (
  input logic               clk,
  input logic               rst,
  tone_seq_player_if.slave  bus
);

  localparam logic [CW-1:0] TONE_LAST = CW'(TONE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  seq_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW:0]   r_len_q;
  logic [AW-1:0] r_idx;
  tone_t         r_tone_sel;
  logic          r_se;
  logic          r_busy;
  logic          r_done;

  logic [AW:0]   w_len_c;
  logic [AW-1:0] w_rd_addr;
  tone_t         w_rd_tone;
  logic [CW-1:0] w_on_start;
  logic [CW-1:0] w_on_run;
  logic          w_more;

  assign w_len_c = (32'(bus.len) > DEPTH) ? (AW+1)'(DEPTH) : bus.len;

  // Read address is the entry about to be loaded on the next TONE-entry edge.
  assign w_rd_addr = (r_state == IDLE) ? '0 : r_idx + AW'(1);
  assign w_more    = ((AW+1)'(r_idx) + (AW+1)'(1)) < r_len_q;

`ifdef TONE_SPEEDUP_EN
  function automatic logic [CW-1:0] on_last(input logic [AW:0] l);
    logic [CW-1:0] v;
    if (32'(l) >= 32'd14)
      v = CW'(TONE_CYC >> 2);
    else if (32'(l) >= 32'd6)
      v = CW'(TONE_CYC >> 1);
    else
      v = CW'(TONE_CYC);
    if (v == '0)
      v = CW'(1);
    return v - CW'(1);
  endfunction

  assign w_on_start = on_last(w_len_c);
  assign w_on_run   = on_last(r_len_q);
`else
  assign w_on_start = TONE_LAST;
  assign w_on_run   = TONE_LAST;
`endif

  tone_seq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_tone (bus.wr_tone),
    .i_rd_addr (w_rd_addr),
    .o_rd_tone (w_rd_tone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_len_q    <= '0;
      r_idx      <= '0;
      r_tone_sel <= '0;
      r_se       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_len_c == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= TONE;
              r_se       <= 1'b1;
              r_busy     <= 1'b1;
              r_tone_sel <= w_rd_tone;
              r_idx      <= '0;
              r_cnt      <= w_on_start;
              r_len_q    <= w_len_c;
            end
          end
        end
        TONE: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_se    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= GAP;
            r_se    <= 1'b0;
            r_cnt   <= GAP_LAST;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        GAP: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            if (w_more) begin
              r_state    <= TONE;
              r_se       <= 1'b1;
              r_idx      <= r_idx + AW'(1);
              r_tone_sel <= w_rd_tone;
              r_cnt      <= w_on_run;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tone_sel = r_tone_sel;
  assign bus.SE       = r_se;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.idx      = r_idx;

endmodule
